mem_ctrl: RTL and testbench

Single-port 256×16 word memory with a registered request/acknowledge front end. It sits directly downstream of the processor control FSM. It takes the MAR address, MDR write data and read/write select, and returns read data destined for MDR. It inserts a configurable number of wait states and provides a side-band load port so a bench or boot path can preload programs while the processor is idle.

---
 rtl/mem_ctrl_if.sv | 14 +
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/acknowledge bus between the processor control FSM (master) and mem_ctrl (slave).
interface mem_ctrl_if;
  logic        req;
  logic        rw;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;
  logic        busy;
  logic        perr;

  modport master (output req, rw, addr, wdata, input  rdata, ack, busy, perr);
  modport slave  (input  req, rw, addr, wdata, output rdata, ack, busy, perr);
endinterface

// File: rtl/mem_ctrl.sv
// 256x16 single-port memory with registered req/ack front end, wait states and a side-band load port.
// Define MEM_PARITY_EN to store an even-parity bit per word and report read parity errors on perr.
module mem_ctrl #(
  parameter int unsigned  WAIT_STATES = 1,
  parameter logic [15:0]  INIT_VAL    = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  mem_ctrl_if.slave   bus,
  input  logic        ld_en,
  input  logic        ld_clr,
  input  logic [7:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic        inj_perr
);

`ifdef MEM_PARITY_EN
  localparam int unsigned MW = 17;
  localparam logic [MW-1:0] FLIP_MASK = {1'b1, 16'd0};
  function automatic logic [MW-1:0] enc(input logic [15:0] d);
    return {^d, d};
  endfunction
`else
  localparam int unsigned MW = 16;
  localparam logic [MW-1:0] FLIP_MASK = '0;
  function automatic logic [MW-1:0] enc(input logic [15:0] d);
    return d;
  endfunction
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_CLEAR} state_e;

  state_e      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  clr_cnt_q, clr_cnt_d;
  logic [7:0]  addr_q, addr_d;
  logic        rw_q, rw_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        perr_q, perr_d;

  logic [MW-1:0] mem [256];
  logic [MW-1:0] rd_word;
  logic          rd_perr;
  logic          mem_we;
  logic [7:0]    mem_waddr;
  logic [MW-1:0] mem_wword;

  assign rd_word = mem[addr_q];
`ifdef MEM_PARITY_EN
  assign rd_perr = rd_word[16] ^ (^rd_word[15:0]);
`else
  assign rd_perr = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    clr_cnt_d  = clr_cnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ack_d      = ack_q;
    busy_d     = busy_q;
    perr_d     = perr_q;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wword  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (ld_en && ld_clr) begin
          clr_cnt_d = 8'd0;
          busy_d    = 1'b1;
          state_d   = S_CLEAR;
        end else if (ld_en) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr;
          mem_wword = enc(ld_data) ^ (inj_perr ? FLIP_MASK : '0);
        end else if (bus.req) begin
          addr_d     = bus.addr;
          rw_d       = bus.rw;
          wdata_d    = bus.wdata;
          wait_cnt_d = 4'(WAIT_STATES);
          busy_d     = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          if (rw_q) begin
            rdata_d = rd_word[15:0];
            perr_d  = rd_perr;
          end else begin
            mem_we    = 1'b1;
            mem_wword = enc(wdata_q);
            perr_d    = 1'b0;
          end
          ack_d   = 1'b1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wword = enc(INIT_VAL);
        clr_cnt_d = clr_cnt_q + 8'd1;
        if (clr_cnt_q == 8'hFF) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= 4'd0;
      clr_cnt_q  <= 8'd0;
      addr_q     <= 8'd0;
      rw_q       <= 1'b0;
      wdata_q    <= 16'd0;
      rdata_q    <= 16'd0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      clr_cnt_q  <= clr_cnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
    end
  end

  // NOTE: the array has no reset; reset only blocks the write so an aborted access leaves contents intact.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wword;
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.perr  = perr_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, hand-written corner sequences and
// randomized accesses scored against an array model of the memory contents.
module tb_mem_ctrl;
  localparam int          WS   = 1;
  localparam int          WS3  = 3;
  localparam logic [15:0] INIT = 16'hA5C3;
`ifdef MEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_en, ld_clr, inj_perr;
  logic [7:0]  ld_addr;
  logic [15:0] ld_data;

  mem_ctrl_if b1();
  mem_ctrl_if b3();

  mem_ctrl #(.WAIT_STATES(WS), .INIT_VAL(INIT)) dut1 (
    .clk(clk), .reset(reset), .bus(b1), .ld_en(ld_en), .ld_clr(ld_clr),
    .ld_addr(ld_addr), .ld_data(ld_data), .inj_perr(inj_perr));

  mem_ctrl #(.WAIT_STATES(WS3), .INIT_VAL(INIT)) dut3 (
    .clk(clk), .reset(reset), .bus(b3), .ld_en(ld_en), .ld_clr(ld_clr),
    .ld_addr(ld_addr), .ld_data(ld_data), .inj_perr(inj_perr));

  always #5 clk = ~clk;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] model_mem [256];
  bit          model_bad [256];
  logic [15:0] last_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [15:0] d, input bit inj);
    ld_en = 1'b1; ld_clr = 1'b0; ld_addr = a; ld_data = d; inj_perr = inj;
    tick();
    ld_en = 1'b0; inj_perr = 1'b0;
    model_mem[a] = d;
    model_bad[a] = inj;
  endtask

  // One complete access on dut1; expectations come from the model, timing from WS arithmetic.
  task automatic cpu(input string tag, input logic rw_i, input logic [7:0] a,
                     input logic [15:0] d, output logic [15:0] rd);
    int          lat, bcnt;
    logic [15:0] exp_rd;
    logic        exp_pe;
    exp_rd = rw_i ? model_mem[a] : last_rd;
    exp_pe = rw_i ? (PAR && model_bad[a]) : 1'b0;
    b1.req = 1'b1; b1.rw = rw_i; b1.addr = a; b1.wdata = d;
    tick();
    lat  = 0;
    bcnt = b1.busy ? 1 : 0;
    while (!b1.ack && lat < 40) begin
      tick();
      lat++;
      if (b1.busy) bcnt++;
    end
    rd = b1.rdata;
    check({tag, " latency"}, lat, WS + 1);
    check({tag, " rdata"}, rd, exp_rd);
    check({tag, " perr"}, b1.perr, exp_pe);
    b1.req = 1'b0;
    tick();
    if (b1.busy) bcnt++;
    check({tag, " ack pulse"}, b1.ack, 1'b0);
    check({tag, " busy cycles"}, bcnt, WS + 2);
    if (rw_i) last_rd = model_mem[a];
    else begin
      model_mem[a] = d;
      model_bad[a] = 1'b0;
    end
  endtask

  initial begin
    vec_t        vecs [6];
    logic [15:0] rd;
    int          lat, cyc, acks, b2b, first, second;
    logic        prev, seen;

    vecs[0] = '{1'b0, 8'hFF, 16'h1234, 16'hBEEF};
    vecs[1] = '{1'b1, 8'hFF, 16'h0000, 16'h1234};
    vecs[2] = '{1'b1, 8'h00, 16'h0000, INIT};
    vecs[3] = '{1'b0, 8'h00, 16'h0F0F, INIT};
    vecs[4] = '{1'b1, 8'h00, 16'h0000, 16'h0F0F};
    vecs[5] = '{1'b1, 8'h10, 16'h0000, 16'hBEEF};

    reset = 1'b1; ld_en = 1'b0; ld_clr = 1'b0; inj_perr = 1'b0;
    ld_addr = 8'd0; ld_data = 16'd0;
    b1.req = 1'b0; b1.rw = 1'b0; b1.addr = 8'd0; b1.wdata = 16'd0;
    b3.req = 1'b0; b3.rw = 1'b0; b3.addr = 8'd0; b3.wdata = 16'd0;
    last_rd = 16'd0;
    tick();
    tick();
    check("reset rdata", b1.rdata, 16'd0);
    check("reset ack", b1.ack, 1'b0);
    check("reset busy", b1.busy, 1'b0);
    check("reset perr", b1.perr, 1'b0);
    reset = 1'b0;
    tick();

    // Clear fills both memories; busy must cover exactly 256 samples after the accept edge.
    ld_en = 1'b1; ld_clr = 1'b1;
    tick();
    ld_en = 1'b0; ld_clr = 1'b0;
    cyc = 0;
    while (b1.busy && cyc < 400) begin
      cyc++;
      tick();
    end
    check("clear busy cycles", cyc, 256);
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = INIT;
      model_bad[i] = 1'b0;
    end

    load(8'h10, 16'hBEEF, 1'b0);
    cpu("load then read", 1'b1, 8'h10, 16'h0000, rd);

    for (int i = 0; i < 6; i++) begin
      cpu($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d table", i), rd, vecs[i].exp_rd);
    end

    // ld_en and req together: load wins, req is accepted on the following edge.
    ld_en = 1'b1; ld_addr = 8'h20; ld_data = 16'h5A5A;
    b1.req = 1'b1; b1.rw = 1'b1; b1.addr = 8'h20;
    tick();
    ld_en = 1'b0;
    model_mem[8'h20] = 16'h5A5A;
    model_bad[8'h20] = 1'b0;
    check("prio load first", b1.busy, 1'b0);
    lat = 0;
    while (!b1.ack && lat < 40) begin
      tick();
      lat++;
    end
    check("prio ack latency", lat, WS + 2);
    check("prio rdata", b1.rdata, 16'h5A5A);
    b1.req = 1'b0;
    tick();
    last_rd = 16'h5A5A;

    // req held through ack: two accesses in 2*(WS+3) edges, acks never adjacent.
    load(8'h30, 16'h3030, 1'b0);
    b1.req = 1'b1; b1.rw = 1'b1; b1.addr = 8'h30;
    acks = 0; b2b = 0; prev = 1'b0; first = -1; second = -1;
    for (int i = 0; i < 2 * (WS + 3); i++) begin
      tick();
      if (b1.ack) begin
        acks++;
        if (prev) b2b++;
        if (first < 0) first = i;
        else second = i;
      end
      prev = b1.ack;
    end
    b1.req = 1'b0;
    check("held ack count", acks, 2);
    check("held back-to-back", b2b, 0);
    check("held spacing", second - first, WS + 3);
    check("held rdata", b1.rdata, 16'h3030);
    tick();
    check("held idle after", b1.busy, 1'b0);
    last_rd = 16'h3030;

    // Reset while a WAIT_STATES=3 write is still counting down.
    load(8'h40, 16'h4444, 1'b0);
    b3.req = 1'b1; b3.rw = 1'b0; b3.addr = 8'h40; b3.wdata = 16'hDEAD;
    tick();
    seen = 1'b0;
    repeat (2) begin
      tick();
      seen |= b3.ack;
    end
    reset = 1'b1; b3.req = 1'b0;
    tick();
    seen |= b3.ack;
    check("rst mid ack never", seen, 1'b0);
    check("rst mid busy", b3.busy, 1'b0);
    check("rst mid rdata", b3.rdata, 16'd0);
    check("rst mid perr", b3.perr, 1'b0);
    reset = 1'b0;
    last_rd = 16'd0;
    tick();
    b3.req = 1'b1; b3.rw = 1'b1; b3.addr = 8'h40;
    tick();
    lat = 0;
    while (!b3.ack && lat < 40) begin
      tick();
      lat++;
    end
    check("rst mid read latency", lat, WS3 + 1);
    check("rst mid word kept", b3.rdata, 16'h4444);
    b3.req = 1'b0;
    tick();

    load(8'h50, 16'h0001, 1'b1);
    cpu("parity injected", 1'b1, 8'h50, 16'h0000, rd);
    load(8'h50, 16'h0001, 1'b0);
    cpu("parity clean", 1'b1, 8'h50, 16'h0000, rd);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0)
        load(8'hC0 | 8'($urandom_range(0, 15)), 16'($urandom), 1'($urandom_range(0, 1)));
      else
        cpu($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
            8'hC0 | 8'($urandom_range(0, 15)), 16'($urandom), rd);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
